// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole hit judge.
// Provides the FSM state encoding and a one-hot to index decoder with validity flag.
package mole_pkg;

  localparam int         NUM_HOLES = 8;
  localparam int         IDX_W     = 3;
  localparam logic [7:0] BCD_MAX   = 8'h99;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RESULT = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } mole_dec_t;

  // vld is set only when exactly one bit is high; idx is then its position.
  function automatic mole_dec_t onehot_decode(input logic [NUM_HOLES-1:0] oh);
    mole_dec_t   r;
    int unsigned ones;
    r.vld = 1'b0;
    r.idx = '0;
    ones  = 0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      if (oh[i]) begin
        ones++;
        r.idx = IDX_W'(i);
      end
    end
    r.vld = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register: clear, +1, -1 per cycle, saturating at 00 and 99.
// Registered output, one-cycle update; no backpressure (clear > dec > inc).
module bcd_score_counter
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       clr_i,
  output logic [7:0] score_o
);

  logic [7:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clr_i) begin
      score_d = 8'h00;
    end else if (dec_i) begin
      if (score_q != 8'h00) begin
        if (score_q[3:0] == 4'd0) begin
          score_d = {score_q[7:4] - 4'd1, 4'd9};
        end else begin
          score_d = {score_q[7:4], score_q[3:0] - 4'd1};
        end
      end
    end else if (inc_i) begin
      if (score_q != BCD_MAX) begin
        if (score_q[3:0] == 4'd9) begin
          score_d = {score_q[7:4] + 4'd1, 4'd0};
        end else begin
          score_d = {score_q[7:4], score_q[3:0] + 4'd1};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= 8'h00;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/mole_hit_judge.sv
// Judges one whack-a-mole round per accepted mole_stb and keeps a BCD score.
// Switch-to-hit latency 3 clk; no backpressure. MOLE_PENALTY_EN enables wrong-switch penalties.
module mole_hit_judge
  import mole_pkg::*;
#(
  parameter int WINDOW = 50_000_000,
  parameter int WIN_W  = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HOLES-1:0] mole_led,
  input  logic                 mole_stb,
  input  logic [NUM_HOLES-1:0] sw,
  output logic                 hit,
  output logic                 miss,
  output logic                 bad_mole,
  output logic                 armed,
  output logic [IDX_W-1:0]     mole_idx,
  output logic [7:0]           score
);

  logic [NUM_HOLES-1:0] sw_meta_q, sw_sync_q, sw_prev_q;
  logic [NUM_HOLES-1:0] sw_rise;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             bad_q, bad_d;
  logic             pen_d;

  mole_dec_t dec;
  logic      stb_ok, stb_bad;
  logic      good_whack, pen_whack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_prev_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      sw_prev_q <= sw_sync_q;
    end
  end

  // A switch held high never re-triggers; only a fresh 0->1 counts.
  assign sw_rise = sw_sync_q & ~sw_prev_q;

  assign dec        = onehot_decode(mole_led);
  assign stb_ok     = mole_stb & dec.vld;
  assign stb_bad    = mole_stb & ~dec.vld;
  assign good_whack = sw_rise[idx_q];

`ifdef MOLE_PENALTY_EN
  logic [NUM_HOLES-1:0] hole_mask;
  assign hole_mask = NUM_HOLES'(1) << idx_q;
  assign pen_whack = |(sw_rise & ~hole_mask);
`else
  assign pen_whack = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    bad_d   = 1'b0;
    pen_d   = 1'b0;
    case (state_q)
      IDLE, RESULT: begin
        state_d = IDLE;
        bad_d   = stb_bad;
        if (stb_ok) begin
          idx_d   = dec.idx;
          cnt_d   = '0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        cnt_d = cnt_q + 1'b1;
        bad_d = stb_bad;
        // Penalty beats a correct whack, a correct whack beats timeout.
        if (pen_whack) begin
          miss_d  = 1'b1;
          pen_d   = 1'b1;
          state_d = RESULT;
        end else if (good_whack) begin
          hit_d   = 1'b1;
          state_d = RESULT;
        end else if (cnt_q == WIN_W'(WINDOW - 1)) begin
          miss_d  = 1'b1;
          state_d = RESULT;
        end else if (stb_ok) begin
          miss_d  = 1'b1;
        end
        // A valid new mole always re-arms, whatever happened to the old one.
        if (stb_ok) begin
          idx_d   = dec.idx;
          cnt_d   = '0;
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      bad_q   <= bad_d;
    end
  end

  bcd_score_counter u_score (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (hit_d),
    .dec_i  (pen_d),
    .clr_i  (1'b0),
    .score_o(score)
  );

  assign hit      = hit_q;
  assign miss     = miss_q;
  assign bad_mole = bad_q;
  assign armed    = (state_q == ARMED);
  assign mole_idx = idx_q;

endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed self-checking bench for mole_hit_judge with WINDOW=8.
module tb_mole_hit_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mole_led;
  logic       mole_stb;
  logic [7:0] sw;
  logic       hit, miss, bad_mole, armed;
  logic [2:0] mole_idx;
  logic [7:0] score;

  int n_chk  = 0;
  int n_fail = 0;

  mole_hit_judge #(.WINDOW(8), .WIN_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .mole_led(mole_led),
    .mole_stb(mole_stb),
    .sw      (sw),
    .hit     (hit),
    .miss    (miss),
    .bad_mole(bad_mole),
    .armed   (armed),
    .mole_idx(mole_idx),
    .score   (score)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] led);
    mole_led = led;
    mole_stb = 1'b1;
    tick(1);
    mole_stb = 1'b0;
    mole_led = 8'h00;
  endtask

  task automatic do_hit(input int idx);
    strobe(8'(1 << idx));
    sw[idx] = 1'b1;
    tick(3);
    chk1("loop_hit", hit, 1'b1);
    sw = 8'h00;
    tick(4);
  endtask

  int armed_cnt, miss_cnt, hit_cnt;

  initial begin
    rst      = 1'b1;
    mole_led = 8'h00;
    mole_stb = 1'b0;
    sw       = 8'h00;
    tick(2);
    chk1("rst_hit", hit, 1'b0);
    chk1("rst_miss", miss, 1'b0);
    chk1("rst_bad", bad_mole, 1'b0);
    chk1("rst_armed", armed, 1'b0);
    chk8("rst_idx", {5'd0, mole_idx}, 8'h00);
    chk8("rst_score", score, 8'h00);
    rst = 1'b0;
    tick(1);

    // Basic hit on hole 4, three-cycle switch latency.
    strobe(8'h10);
    chk1("t1_armed", armed, 1'b1);
    chk8("t1_idx", {5'd0, mole_idx}, 8'h04);
    sw[4] = 1'b1;
    tick(2);
    chk1("t1_hit_early", hit, 1'b0);
    tick(1);
    chk1("t1_hit", hit, 1'b1);
    chk8("t1_score", score, 8'h01);
    chk1("t1_disarm", armed, 1'b0);
    tick(1);
    chk1("t1_hit_pulse", hit, 1'b0);
    sw = 8'h00;
    tick(4);

    // Timeout: exactly 8 armed cycles then a single miss.
    strobe(8'h04);
    armed_cnt = 0;
    miss_cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      if (armed) armed_cnt++;
      if (miss) miss_cnt++;
      tick(1);
    end
    chk8("t2_armed_len", 8'(armed_cnt), 8'd8);
    chk8("t2_miss_cnt", 8'(miss_cnt), 8'd1);
    chk8("t2_score", score, 8'h01);

    // Invalid mole patterns.
    strobe(8'h00);
    chk1("t3_bad0", bad_mole, 1'b1);
    chk1("t3_armed0", armed, 1'b0);
    tick(1);
    chk1("t3_bad0_pulse", bad_mole, 1'b0);
    strobe(8'h03);
    chk1("t3_bad3", bad_mole, 1'b1);
    chk1("t3_armed3", armed, 1'b0);
    tick(1);

    // Pre-emption: old round misses, new one restarts its window.
    strobe(8'h04);
    tick(2);
    strobe(8'h80);
    chk1("t5_miss", miss, 1'b1);
    chk8("t5_idx", {5'd0, mole_idx}, 8'h07);
    chk1("t5_armed", armed, 1'b1);
    tick(4);
    chk1("t5_still_armed", armed, 1'b1);
    sw[7] = 1'b1;
    tick(3);
    chk1("t5_hit", hit, 1'b1);
    chk8("t5_score", score, 8'h02);
    sw = 8'h00;
    tick(4);

    // Held switch does not score in the next round.
    sw[3] = 1'b1;
    tick(4);
    strobe(8'h08);
    hit_cnt  = 0;
    miss_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (hit) hit_cnt++;
      if (miss) miss_cnt++;
      tick(1);
    end
    chk8("t6_hit_cnt", 8'(hit_cnt), 8'd0);
    chk8("t6_miss_cnt", 8'(miss_cnt), 8'd1);
    chk8("t6_score", score, 8'h02);
    sw = 8'h00;
    tick(4);

    // BCD roll-over and saturation.
    for (int i = 0; i < 7; i++) do_hit(i % 8);
    chk8("t4_score09", score, 8'h09);
    do_hit(1);
    chk8("t4_score10", score, 8'h10);
    for (int i = 0; i < 89; i++) do_hit((i * 3) % 8);
    chk8("t4_score99", score, 8'h99);
    strobe(8'h02);
    sw[1] = 1'b1;
    tick(3);
    chk1("t4_hit_sat", hit, 1'b1);
    chk8("t4_score_sat", score, 8'h99);
    sw = 8'h00;
    tick(4);

    // Wrong-switch whack on hole 5.
    strobe(8'h20);
    sw[0] = 1'b1;
    tick(3);
`ifdef MOLE_PENALTY_EN
    chk1("p_miss99", miss, 1'b1);
    chk8("p_score98", score, 8'h98);
`else
    chk1("t7_no_hit", hit, 1'b0);
    chk1("t7_no_miss", miss, 1'b0);
    chk1("t7_armed", armed, 1'b1);
    chk8("t7_score", score, 8'h99);
`endif
    sw = 8'h00;
    tick(1);

    // Mid-round reset clears everything asynchronously.
    strobe(8'h20);
    tick(1);
    rst = 1'b1;
    #1;
    chk1("t8_armed", armed, 1'b0);
    chk8("t8_idx", {5'd0, mole_idx}, 8'h00);
    chk8("t8_score", score, 8'h00);
    chk1("t8_hit", hit, 1'b0);
    chk1("t8_miss", miss, 1'b0);
    #2;
    rst = 1'b0;
    tick(4);
    chk1("t8_idle", armed, 1'b0);

`ifdef MOLE_PENALTY_EN
    strobe(8'h01);
    sw[1] = 1'b1;
    tick(3);
    chk1("p_miss00", miss, 1'b1);
    chk8("p_score00", score, 8'h00);
    sw = 8'h00;
    tick(4);
    for (int i = 0; i < 10; i++) do_hit(2);
    chk8("p_score10", score, 8'h10);
    strobe(8'h20);
    sw[0] = 1'b1;
    tick(3);
    chk1("p_miss", miss, 1'b1);
    chk8("p_score09", score, 8'h09);
    chk1("p_disarm", armed, 1'b0);
    sw = 8'h00;
    tick(4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
